// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder.
// Accepts one request at a time, waits WAIT_CYCLES wait states, then
// performs the access on an internal synchronous RAM and holds the
// response until the initiator consumes it.
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);

  // RAM index width; a one-word RAM still needs a one-bit index.
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wait-state counter is 4 bits wide, enough for the 0..15 range.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   ram_q [DEPTH];

  logic                    in_range_d;
  logic                    access_d;
  logic [RAM_AW-1:0]       ram_idx_d;

  // When the address space fits entirely inside the RAM every address is
  // legal, so the comparison collapses to a constant instead of comparing
  // against a value the address can never reach.
  generate
    if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
      assign in_range_d = 1'b1;
    end else begin : g_partial_range
      assign in_range_d = (addr_q < ADDR_WIDTH'(DEPTH));
    end
  endgenerate

  // The access happens on the edge where WAIT sees an expired counter.
  assign access_d  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign ram_idx_d = addr_q[RAM_AW-1:0];

  // Handshake flags are pure decodes of the state register, so there is no
  // combinational path from any input to any output.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // RAM write port: contents survive reset, but a reset on the access edge
  // suppresses the write so an aborted transaction leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && access_d && wr_q && in_range_d) begin
      ram_q[ram_idx_d] <= wdata_q;
    end
  end

  // Transaction FSM: capture request, count wait states, access, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= ST_RESP;
            if (!in_range_d) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end else begin
              err_q   <= 1'b0;
              // A write echoes its data; a read returns the stored word.
              rdata_q <= wr_q ? wdata_q : ram_q[ram_idx_d];
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover the default
// configuration, DEPTH=128 and WAIT_CYCLES=0.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst        [3];
  logic       req_valid  [3];
  logic       req_ready  [3];
  logic       req_write  [3];
  logic [7:0] req_addr   [3];
  logic [7:0] req_wdata  [3];
  logic       resp_valid [3];
  logic       resp_ready [3];
  logic [7:0] resp_rdata [3];
  logic       resp_err   [3];
  logic       busy       [3];

  int checks = 0;
  int errors = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      mem_responder #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .DEPTH      ((gi == 1) ? 128 : 256),
        .WAIT_CYCLES((gi == 2) ? 0 : 2)
      ) u_dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_write (req_write[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .resp_valid(resp_valid[gi]),
        .resp_ready(resp_ready[gi]),
        .resp_rdata(resp_rdata[gi]),
        .resp_err  (resp_err[gi]),
        .busy      (busy[gi])
      );
    end
  endgenerate

  function automatic int wc(input int d);
    return (d == 2) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // One complete transaction with resp_ready held high. Called at a negedge,
  // returns at a negedge with the DUT back in IDLE.
  task automatic txn(input int d, input logic wr, input logic [7:0] addr,
                     input logic [7:0] wdata, input logic [7:0] exp_rd,
                     input logic exp_err, input string tag, output int hs);
    int k;
    logic seen;
    check_eq({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    hs = int'(cyc);
    // Scramble the request lines to prove they were captured at handshake.
    req_valid[d] = 1'b0;
    req_addr[d]  = ~addr;
    req_wdata[d] = ~wdata;
    req_write[d] = ~wr;
    k = 1;
    seen = resp_valid[d];
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      seen = resp_valid[d];
    end
    check_eq({tag, " latency"}, 32'(k - 1), 32'(wc(d) + 1));
    check_eq({tag, " rdata"}, 32'(resp_rdata[d]), 32'(exp_rd));
    check_eq({tag, " err"}, 32'(resp_err[d]), 32'(exp_err));
    @(negedge clk);
    check_eq({tag, " valid_drop"}, 32'(resp_valid[d]), 32'd0);
    check_eq({tag, " idle"}, 32'(busy[d]), 32'd0);
  endtask

  initial begin : main
    int hs1;
    int hs2;
    int k;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 8'h00; req_wdata[d] = 8'h00; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Reset state
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst%0d req_ready", d), 32'(req_ready[d]), 32'd1);
      check_eq($sformatf("rst%0d resp_valid", d), 32'(resp_valid[d]), 32'd0);
      check_eq($sformatf("rst%0d busy", d), 32'(busy[d]), 32'd0);
      check_eq($sformatf("rst%0d rdata", d), 32'(resp_rdata[d]), 32'h00);
      check_eq($sformatf("rst%0d err", d), 32'(resp_err[d]), 32'd0);
    end

    // Basic write then read
    txn(0, 1'b1, 8'h10, 8'hA5, 8'hA5, 1'b0, "wr10", hs1);
    txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "rd10", hs1);

    // Response backpressure with a stray request pulse
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h10; resp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    k = 1;
    while (!resp_valid[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("bp latency", 32'(k - 1), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp%0d valid", i), 32'(resp_valid[0]), 32'd1);
      check_eq($sformatf("bp%0d rdata", i), 32'(resp_rdata[0]), 32'hA5);
      check_eq($sformatf("bp%0d req_ready", i), 32'(req_ready[0]), 32'd0);
      req_valid[0] = (i == 2);
      req_write[0] = 1'b1;
      req_wdata[0] = 8'h00;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check_eq("bp held valid", 32'(resp_valid[0]), 32'd1);
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check_eq("bp consumed valid", 32'(resp_valid[0]), 32'd0);
    check_eq("bp consumed req_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, "bp reread", hs1);

    // Top address of a full-range RAM is legal
    txn(0, 1'b1, 8'hFF, 8'h3C, 8'h3C, 1'b0, "wrFF", hs1);
    txn(0, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b0, "rdFF", hs1);

    // DEPTH=128 boundaries
    txn(1, 1'b1, 8'h00, 8'h42, 8'h42, 1'b0, "d128 wr00", hs1);
    txn(1, 1'b1, 8'h80, 8'h33, 8'h00, 1'b1, "d128 wr80", hs1);
    txn(1, 1'b0, 8'h00, 8'h00, 8'h42, 1'b0, "d128 rd00", hs1);
    txn(1, 1'b1, 8'h7F, 8'h5C, 8'h5C, 1'b0, "d128 wr7F", hs1);
    txn(1, 1'b0, 8'h7F, 8'h00, 8'h5C, 1'b0, "d128 rd7F", hs1);
    txn(1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1, "d128 rd80", hs1);

    // Reset on the access edge aborts the write
    txn(0, 1'b1, 8'h20, 8'h11, 8'h11, 1'b0, "preload20", hs1);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 8'hFF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_eq("abort busy after", 32'(busy[0]), 32'd0);
    check_eq("abort resp_valid", 32'(resp_valid[0]), 32'd0);
    check_eq("abort req_ready", 32'(req_ready[0]), 32'd1);
    check_eq("abort rdata", 32'(resp_rdata[0]), 32'h00);
    txn(0, 1'b0, 8'h20, 8'h00, 8'h11, 1'b0, "abort rd20", hs1);

    // WAIT_CYCLES=0 back-to-back
    txn(2, 1'b1, 8'h05, 8'h7E, 8'h7E, 1'b0, "w0 wr05", hs1);
    txn(2, 1'b0, 8'h05, 8'h00, 8'h7E, 1'b0, "w0 rd05", hs2);
    check_eq("w0 initiation", 32'(hs2 - hs1), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
